pulse_stretcher: RTL and testbench

Converts a single-cycle trigger pulse into a registered output level held high for a programmable number of clock cycles. It performs the inverse of the rising-edge pulse detection used on the timer inputs. It drives timer-side level consumers such as the buzzer enable, LED flash and alarm strobe from one-cycle event pulses. Optional retrigger and a minimum forced-low gap give clean, countable output pulses.

---
 rtl/pulse_stretcher.sv | 142 ++++++++++++++
 tb/tb_pulse_stretcher.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pulse_stretcher.sv
// Stretches a one-cycle trigger into an OUT level held for LEN cycles, with
// optional retrigger, a forced-low gap after each pulse, abort and a DONE strobe.
module pulse_stretcher #(
    parameter int CNT_W     = 16,
    parameter bit RETRIGGER = 1'b0,
    parameter int MIN_GAP   = 0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             TRIG,
    input  logic [CNT_W-1:0] LEN,
    input  logic             ABORT,
    output logic             OUT,
    output logic             BUSY,
    output logic             DONE
);

    localparam int GAP_W = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'((MIN_GAP > 0) ? (MIN_GAP - 1) : 0);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             out_q, out_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             trig_ok_s;

    assign trig_ok_s = TRIG && (LEN != {CNT_W{1'b0}});

    // Next-state and next-output computation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        out_d   = out_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!ABORT && trig_ok_s) begin
                    state_d = S_ACTIVE;
                    cnt_d   = LEN - {{(CNT_W-1){1'b0}}, 1'b1};
                    out_d   = 1'b1;
                    busy_d  = 1'b1;
                end else begin
                    state_d = S_IDLE;
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end
            end
            S_ACTIVE: begin
                if (ABORT) begin
                    state_d = S_IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    gap_d   = {GAP_W{1'b0}};
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (RETRIGGER && trig_ok_s) begin
                    cnt_d   = LEN - {{(CNT_W-1){1'b0}}, 1'b1};
                    out_d   = 1'b1;
                    busy_d  = 1'b1;
                end else if (cnt_q == {CNT_W{1'b0}}) begin
                    out_d   = 1'b0;
                    done_d  = 1'b1;
                    if (MIN_GAP > 0) begin
                        state_d = S_GAP;
                        gap_d   = GAP_INIT;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end else begin
                    cnt_d   = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_GAP: begin
                // The last gap cycle may already launch the next pulse, so the
                // low time is exactly MIN_GAP cycles counting the DONE cycle.
                if (ABORT) begin
                    state_d = S_IDLE;
                    gap_d   = {GAP_W{1'b0}};
                    out_d   = 1'b0;
                    busy_d  = 1'b0;
                end else if (gap_q == {GAP_W{1'b0}}) begin
                    if (trig_ok_s) begin
                        state_d = S_ACTIVE;
                        cnt_d   = LEN - {{(CNT_W-1){1'b0}}, 1'b1};
                        out_d   = 1'b1;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                        out_d   = 1'b0;
                        busy_d  = 1'b0;
                    end
                end else begin
                    gap_d   = gap_q - {{(GAP_W-1){1'b0}}, 1'b1};
                    out_d   = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = {CNT_W{1'b0}};
                gap_d   = {GAP_W{1'b0}};
                out_d   = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            gap_q   <= {GAP_W{1'b0}};
            out_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign OUT  = out_q;
    assign BUSY = busy_q;
    assign DONE = done_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: three configurations (plain, retrigger, MIN_GAP=3) share one
// stimulus stream and are checked cycle by cycle against hand-derived patterns.
module tb_pulse_stretcher;

    logic        CLK;
    logic        RST;
    logic        TRIG;
    logic [15:0] LEN;
    logic        ABORT;
    logic        out_a, busy_a, done_a;
    logic        out_r, busy_r, done_r;
    logic        out_g, busy_g, done_g;

    int n_checks = 0;
    int n_fail   = 0;

    pulse_stretcher #(.CNT_W(16), .RETRIGGER(1'b0), .MIN_GAP(0)) dut_a (
        .CLK(CLK), .RST(RST), .TRIG(TRIG), .LEN(LEN), .ABORT(ABORT),
        .OUT(out_a), .BUSY(busy_a), .DONE(done_a)
    );
    pulse_stretcher #(.CNT_W(16), .RETRIGGER(1'b1), .MIN_GAP(0)) dut_r (
        .CLK(CLK), .RST(RST), .TRIG(TRIG), .LEN(LEN), .ABORT(ABORT),
        .OUT(out_r), .BUSY(busy_r), .DONE(done_r)
    );
    pulse_stretcher #(.CNT_W(16), .RETRIGGER(1'b0), .MIN_GAP(3)) dut_g (
        .CLK(CLK), .RST(RST), .TRIG(TRIG), .LEN(LEN), .ABORT(ABORT),
        .OUT(out_g), .BUSY(busy_g), .DONE(done_g)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Bit n-1-j of the stimulus patterns drives edge j; the same bit of the
    // expectation patterns is the output value in the cycle after edge j.
    task automatic run_seq(input string tag, input int n,
                           input logic [23:0] trig_p, input logic [23:0] ab_p,
                           input logic [15:0] len_v,
                           input logic [23:0] eo_a, input logic [23:0] ed_a, input logic [23:0] eb_a,
                           input logic [23:0] eo_r, input logic [23:0] ed_r, input logic [23:0] eb_r,
                           input logic [23:0] eo_g, input logic [23:0] ed_g, input logic [23:0] eb_g);
        for (int j = 0; j < n; j++) begin
            int b = n - 1 - j;
            TRIG  = trig_p[b];
            ABORT = ab_p[b];
            LEN   = len_v;
            tick();
            check_eq($sformatf("%s_a_out_c%0d", tag, j + 1), out_a, eo_a[b]);
            check_eq($sformatf("%s_a_done_c%0d", tag, j + 1), done_a, ed_a[b]);
            check_eq($sformatf("%s_a_busy_c%0d", tag, j + 1), busy_a, eb_a[b]);
            check_eq($sformatf("%s_r_out_c%0d", tag, j + 1), out_r, eo_r[b]);
            check_eq($sformatf("%s_r_done_c%0d", tag, j + 1), done_r, ed_r[b]);
            check_eq($sformatf("%s_r_busy_c%0d", tag, j + 1), busy_r, eb_r[b]);
            check_eq($sformatf("%s_g_out_c%0d", tag, j + 1), out_g, eo_g[b]);
            check_eq($sformatf("%s_g_done_c%0d", tag, j + 1), done_g, ed_g[b]);
            check_eq($sformatf("%s_g_busy_c%0d", tag, j + 1), busy_g, eb_g[b]);
        end
        TRIG  = 1'b0;
        ABORT = 1'b0;
    endtask

    task automatic settle(input int n);
        TRIG  = 1'b0;
        ABORT = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        RST   = 1'b1;
        TRIG  = 1'b0;
        ABORT = 1'b0;
        LEN   = 16'd0;
        repeat (3) tick();
        check_eq("rst_a_out", out_a, 1'b0);
        check_eq("rst_a_busy", busy_a, 1'b0);
        check_eq("rst_a_done", done_a, 1'b0);
        check_eq("rst_g_busy", busy_g, 1'b0);
        RST = 1'b0;
        settle(2);

        // Basic LEN=5 pulse
        run_seq("basic", 10, 10'b1000000000, 10'b0, 16'd5,
                10'b1111100000, 10'b0000010000, 10'b1111100000,
                10'b1111100000, 10'b0000010000, 10'b1111100000,
                10'b1111100000, 10'b0000010000, 10'b1111111100);
        settle(4);

        run_seq("len0", 4, 4'b1000, 4'b0, 16'd0,
                4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        settle(2);

        run_seq("len1", 6, 6'b100000, 6'b0, 16'd1,
                6'b100000, 6'b010000, 6'b100000,
                6'b100000, 6'b010000, 6'b100000,
                6'b100000, 6'b010000, 6'b111100);
        settle(4);

        // Second trigger two edges after the first
        run_seq("retrig", 10, 10'b1010000000, 10'b0, 16'd4,
                10'b1111000000, 10'b0000100000, 10'b1111000000,
                10'b1111110000, 10'b0000001000, 10'b1111110000,
                10'b1111000000, 10'b0000100000, 10'b1111111000);
        settle(4);

        // Trigger held high every cycle, LEN=2
        run_seq("b2b", 12, 12'b111111111111, 12'b0, 16'd2,
                12'b110110110110, 12'b001001001001, 12'b110110110110,
                12'b111111111111, 12'b000000000000, 12'b111111111111,
                12'b110001100011, 12'b001000010000, 12'b111111111111);
        settle(8);

        run_seq("abort", 6, 6'b100000, 6'b000100, 16'd10,
                6'b111000, 6'b0, 6'b111000,
                6'b111000, 6'b0, 6'b111000,
                6'b111000, 6'b0, 6'b111000);
        settle(3);

        run_seq("abtrig", 4, 4'b1000, 4'b1000, 16'd5,
                4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0, 4'b0);
        settle(2);

        // Abort landing in the gap of the MIN_GAP instance
        run_seq("abgap", 5, 5'b10000, 5'b00100, 16'd1,
                5'b10000, 5'b01000, 5'b10000,
                5'b10000, 5'b01000, 5'b10000,
                5'b10000, 5'b01000, 5'b11000);
        settle(3);

        // Asynchronous reset in the middle of a long pulse
        TRIG = 1'b1;
        LEN  = 16'd100;
        tick();
        TRIG = 1'b0;
        repeat (9) tick();
        check_eq("prerst_a_out", out_a, 1'b1);
        check_eq("prerst_g_busy", busy_g, 1'b1);
        #3 RST = 1'b1;
        #1;
        check_eq("arst_a_out", out_a, 1'b0);
        check_eq("arst_a_busy", busy_a, 1'b0);
        check_eq("arst_a_done", done_a, 1'b0);
        check_eq("arst_r_out", out_r, 1'b0);
        check_eq("arst_g_out", out_g, 1'b0);
        check_eq("arst_g_busy", busy_g, 1'b0);
        #2 RST = 1'b0;
        tick();
        run_seq("postrst", 5, 5'b10000, 5'b0, 16'd2,
                5'b11000, 5'b00100, 5'b11000,
                5'b11000, 5'b00100, 5'b11000,
                5'b11000, 5'b00100, 5'b11111);
        settle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
